// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU with valid/ready handshake, iterative shifts and signed multiply
// One operation in flight; shifts step one bit per cycle, MUL is a WIDTH-cycle shift-add.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int MUL_EN  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow
);

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010, OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_SGT = 4'b1000, OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SRL = 4'b1101, OP_SLL = 4'b1110, OP_SRA = 4'b1111;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_sh, r_mplier;
  logic [PW-1:0]    r_mcand, r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept, w_is_shift, w_mul_ok, w_multi, w_last, w_load;
  logic             w_quick_ovf, w_ovf_d, w_mul_ovf;
  logic [WIDTH-1:0] w_sum, w_diff, w_quick_res, w_sh_next, w_res_d;
  logic [PW-1:0]    w_addend, w_acc_next;

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign w_accept   = in_valid & in_ready;
  assign w_mul_ok   = (MUL_EN != 0);
  assign w_is_shift = (op == OP_SLL) | (op == OP_SRL) | (op == OP_SRA);
  assign w_multi    = (w_is_shift & (shamt != '0)) | ((op == OP_MUL) & w_mul_ok);
  assign w_sum      = a + b;
  assign w_diff     = a - b;

  // Single-cycle results; shifts by zero pass the source operand straight through
  always_comb begin
    w_quick_res = '0;
    w_quick_ovf = 1'b0;
    case (op)
      OP_AND: w_quick_res = a & b;
      OP_OR:  w_quick_res = a | b;
      OP_NOR: w_quick_res = ~(a | b);
      OP_ADD: begin
        w_quick_res = w_sum;
        w_quick_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_quick_res = w_diff;
        w_quick_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: w_quick_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SGT: w_quick_res = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
      OP_SLL: w_quick_res = b;
      OP_SRL: w_quick_res = a;
      OP_SRA: w_quick_res = a;
      default: w_quick_res = '0;
    endcase
  end

  always_comb begin
    w_sh_next = r_sh >> 1;
    if (r_op == OP_SLL)
      w_sh_next = r_sh << 1;
    else if (r_op == OP_SRA)
      w_sh_next = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
  end

  // Two's-complement multiplier: the top bit of b carries negative weight, so subtract on the last step
  assign w_last     = (r_cnt == CNT_W'(1));
  assign w_addend   = !r_mplier[0] ? '0 : (w_last ? -r_mcand : r_mcand);
  assign w_acc_next = r_acc + w_addend;
  assign w_mul_ovf  = ~((&w_acc_next[PW-1:WIDTH-1]) | ~(|w_acc_next[PW-1:WIDTH-1]));

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_res_d      = w_quick_res;
    w_ovf_d      = w_quick_ovf;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_multi ? S_BUSY : S_DONE;
          w_load       = ~w_multi;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_next = S_DONE;
          w_load       = 1'b1;
          if (r_op == OP_MUL) begin
            w_res_d = w_acc_next[WIDTH-1:0];
            w_ovf_d = w_mul_ovf;
          end else begin
            w_res_d = w_sh_next;
            w_ovf_d = 1'b0;
          end
        end
      end
      S_DONE: begin
        if (out_ready)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_sh     <= '0;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op     <= op;
        r_sh     <= (op == OP_SLL) ? b : a;
        r_mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
        r_mplier <= b;
        r_acc    <= '0;
        r_cnt    <= (op == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(shamt);
      end else if (r_state == S_BUSY) begin
        r_sh     <= w_sh_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_acc    <= w_acc_next;
        r_cnt    <= r_cnt - CNT_W'(1);
      end
      if (w_load) begin
        result   <= w_res_d;
        zero     <= (w_res_d == '0);
        overflow <= w_ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - table-driven scoreboard bench for seq_alu
module tb_seq_alu;
  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    op = '0;
  logic [W-1:0]  a = '0, b = '0;
  logic [SW-1:0] shamt = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          zero, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W), .SHAMT_W(SW), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow)
  );

  typedef struct {
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] shamt;
    logic [W-1:0]  res;
    logic          z;
    logic          ov;
    int            lat;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                     input logic [SW-1:0] sh, input logic [W-1:0] r, input logic z,
                     input logic ov, input int lat);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.shamt = sh; v.res = r; v.z = z; v.ov = ov; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Drive a request, wait for the accept edge, push the expectation, then scramble the inputs
  task automatic issue(input vec_t v);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1; op = v.op; a = v.a; b = v.b; shamt = v.shamt;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_before_accept", W'(in_ready), W'(1));
    @(posedge clk);
    sb.push_back(v);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 4'($urandom); shamt = SW'($urandom);
  endtask

  task automatic collect(input string name, input int hold);
    vec_t e;
    int lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb.pop_front();
    chk({name, "_latency"}, W'(lat), W'(e.lat));
    chk({name, "_result"}, result, e.res);
    chk({name, "_zero"}, W'(zero), W'(e.z));
    chk({name, "_overflow"}, W'(overflow), W'(e.ov));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); a = $urandom; b = $urandom;
      @(posedge clk);
      #1;
      chk({name, "_hold_valid"}, W'(out_valid), W'(1));
      chk({name, "_hold_ready"}, W'(in_ready), W'(0));
      chk({name, "_hold_result"}, result, e.res);
      chk({name, "_hold_flags"}, W'({zero, overflow}), W'({e.z, e.ov}));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_consumed"}, W'(out_valid), W'(0));
    chk({name, "_idle_after"}, W'(in_ready), W'(1));
    chk({name, "_kept_result"}, result, e.res);
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t v;
    int seen;

    add(4'b0010, 32'hFFFF_FFFE, 32'd1300,      5'd0,  32'd1298,      1'b0, 1'b0, 1);
    add(4'b0010, 32'h7FFF_FFFF, 32'd1,         5'd0,  32'h8000_0000, 1'b0, 1'b1, 1);
    add(4'b0110, 32'd5,         32'd5,         5'd0,  32'd0,         1'b1, 1'b0, 1);
    add(4'b0110, 32'h8000_0000, 32'd1,         5'd0,  32'h7FFF_FFFF, 1'b0, 1'b1, 1);
    add(4'b1111, 32'hFFFF_F830, 32'd0,         5'd2,  32'hFFFF_FE0C, 1'b0, 1'b0, 3);
    add(4'b1110, 32'h1234_5678, 32'd31,        5'd2,  32'd124,       1'b0, 1'b0, 3);
    add(4'b1101, 32'h8000_0000, 32'd0,         5'd31, 32'd1,         1'b0, 1'b0, 32);
    add(4'b1111, 32'h8000_0000, 32'd0,         5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 32);
    add(4'b1111, 32'hFFFF_FFFB, 32'd0,         5'd0,  32'hFFFF_FFFB, 1'b0, 1'b0, 1);
    add(4'b0011, 32'hFFFF_FFFD, 32'd7,         5'd0,  32'hFFFF_FFEB, 1'b0, 1'b0, 33);
    add(4'b0011, 32'h0001_0000, 32'h0001_0000, 5'd0,  32'd0,         1'b1, 1'b1, 33);
    add(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'd1,         1'b0, 1'b0, 33);
    add(4'b0011, 32'h7FFF_FFFF, 32'd2,         5'd0,  32'hFFFF_FFFE, 1'b0, 1'b1, 33);
    add(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd0,  32'h0000_F000, 1'b0, 1'b0, 1);
    add(4'b0001, 32'h0000_F0F0, 32'h0000_0F0F, 5'd0,  32'h0000_FFFF, 1'b0, 1'b0, 1);
    add(4'b1100, 32'd0,         32'd0,         5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    add(4'b0111, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'd1,         1'b0, 1'b0, 1);
    add(4'b1000, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'd0,         1'b1, 1'b0, 1);
    add(4'b0101, 32'd9,         32'd9,         5'd3,  32'd0,         1'b1, 1'b0, 1);

    #2;
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_result", result, W'(0));
    chk("reset_flags", W'({zero, overflow}), W'(0));
    chk("reset_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i]);
      collect($sformatf("v%0d", i), i % 3);
    end

    v.op = 4'b0010; v.a = 32'd2; v.b = 32'd3; v.shamt = '0;
    v.res = 32'd5; v.z = 1'b0; v.ov = 1'b0; v.lat = 1;
    issue(v);
    collect("backpressure", 5);

    v.op = 4'b0011; v.a = 32'd1000; v.b = 32'd1000; v.lat = 33;
    issue(v);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", W'(out_valid), W'(0));
    chk("abort_result", result, W'(0));
    chk("abort_flags", W'({zero, overflow}), W'(0));
    chk("abort_in_ready", W'(in_ready), W'(1));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_output", W'(seen), W'(0));

    v.op = 4'b0010; v.a = 32'd2; v.b = 32'd3; v.res = 32'd5; v.z = 1'b0; v.ov = 1'b0; v.lat = 1;
    issue(v);
    collect("post_reset_add", 0);

    v.op = 4'b0101; v.a = 32'hDEAD_BEEF; v.b = 32'h1; v.res = 32'd0; v.z = 1'b1; v.ov = 1'b0; v.lat = 1;
    issue(v);
    collect("post_reset_illegal", 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
